// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM read-stream sequencer.
package bram_stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/byte_skid_fifo.sv
// Two-entry FIFO holding {last, data}; head is presented combinationally on dout.
module byte_skid_fifo
  import bram_stream_pkg::*;
#(
  parameter int W = DEF_DATA_W + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic [1:0]                   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'(FIFO_DEPTH));
endmodule

// File: rtl/bram_stream_reader.sv
// Read-side sequencer: issues BRAM reads for a (start_addr, length) command and streams bytes out.
// BRAM_STREAM_READER_LOOP_EN: repeat the pass from start_addr until stopped.
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);
`ifdef BRAM_STREAM_READER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d;
  logic              inflight_q, inflight_d, inflight_last_q, inflight_last_d;

  logic              rd_en, last_issue, flush, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic [2:0]        occ_net;

  byte_skid_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({inflight_last_q, mem_r_data}),
    .pop   (fifo_pop),
    .flush (flush),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy is counted net of this cycle's pop so a steady 1 byte/clk fits in two slots.
  always_comb begin
    flush      = stop && (state_q == ST_RUN || state_q == ST_DRAIN);
    fifo_pop   = !fifo_empty && m_ready && !flush;
    fifo_push  = inflight_q && !flush && (!fifo_full || fifo_pop);
    occ_net    = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
    rd_en      = (state_q == ST_RUN) && !stop && (occ_net < 3'd2);
    last_issue = (issued_q == len_q - LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (stop)                                state_d = ST_DONE;
        else if (rd_en && last_issue && !LOOP)   state_d = ST_DRAIN;
      end
      ST_DRAIN: if (stop || (fifo_pop && fifo_head[DATA_W])) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    base_d          = base_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && last_issue;
    if (state_q == ST_IDLE && start && length != '0) begin
      base_d   = start_addr;
      addr_d   = start_addr;
      len_d    = length;
      issued_d = '0;
    end else if (rd_en) begin
      if (LOOP && last_issue) begin
        addr_d   = base_q;
        issued_d = '0;
      end else begin
        addr_d   = addr_q + ADDR_W'(1);
        issued_d = issued_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q          <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      base_q          <= base_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  always_comb begin
    busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done       = (state_q == ST_DONE);
    mem_r_en   = rd_en;
    mem_r_addr = addr_q;
    m_valid    = !fifo_empty;
    m_data     = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    m_last     = !fifo_empty && fifo_head[DATA_W];
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a registered-read RAM model.
module tb_bram_stream_reader;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, m_ready = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [8:0] length = 9'd0;
  logic       busy, done, mem_r_en, m_valid, m_last;
  logic [7:0] mem_r_addr, m_data;
  logic [7:0] mem_r_data = 8'h00;
  logic [7:0] ram [256];

  int errors = 0, checks = 0;
  logic [7:0] got_d[$];
  logic       got_l[$];
  int         hs_cyc[$];
  logic [7:0] addr_log[$];
  int         n_hs, n_iss, done_cyc, first_en, first_vld, stall_bad, max_ahead, stop_cyc;
  logic       busy_at_done;

  bram_stream_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .stop(stop), .busy(busy), .done(done), .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr),
    .mem_r_data(mem_r_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_r_en) mem_r_data <= ram[mem_r_addr];

  function automatic logic [7:0] exp_byte(input logic [7:0] a);
    return (a < 8'd4) ? 8'h61 + a : a;
  endfunction

  // Drives one command and records the stream until done or the cycle budget runs out.
  task automatic run_xfer(input logic [7:0] a, input logic [8:0] l, input int mode,
                          input int stop_at, input int budget);
    logic prev_stall;
    logic [7:0] prev_data;
    got_d.delete(); got_l.delete(); hs_cyc.delete(); addr_log.delete();
    n_hs = 0; n_iss = 0; done_cyc = -1; first_en = -1; first_vld = -1;
    stall_bad = 0; max_ahead = 0; stop_cyc = -1; busy_at_done = 1'b1;
    prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk); start = 1'b1; start_addr = a; length = l; m_ready = 1'b0; stop = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk); start = 1'b0; stop = 1'b0;
      if (done) begin done_cyc = k; busy_at_done = busy; break; end
      m_ready = (mode == 0) ? 1'b1 : (k % 3 == 1);
      if (stop_at >= 0 && n_hs == stop_at && stop_cyc < 0 && m_valid) begin
        stop = 1'b1; stop_cyc = k;
      end
      #1;
      if (n_iss - n_hs > max_ahead) max_ahead = n_iss - n_hs;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_bad++;
      if (mem_r_en) begin
        addr_log.push_back(mem_r_addr); n_iss++;
        if (first_en < 0) first_en = k;
      end
      if (m_valid && first_vld < 0) first_vld = k;
      if (m_valid && m_ready && !stop) begin
        got_d.push_back(m_data); got_l.push_back(m_last); hs_cyc.push_back(k); n_hs++;
      end
      prev_stall = m_valid && !m_ready && !stop;
      prev_data  = m_data;
    end
    m_ready = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_last, mem_r_en} !== 5'b0 || m_data !== 8'h00 || mem_r_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b m_valid=%b m_last=%b mem_r_en=%b m_data=%h addr=%h, want all 0",
               busy, done, m_valid, m_last, mem_r_en, m_data, mem_r_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_xfer(8'h00, 9'd4, 0, -1, 30);
    checks++;
    if (got_d.size() != 4 || got_d[0] !== 8'h61 || got_d[1] !== 8'h62 || got_d[2] !== 8'h63 || got_d[3] !== 8'h64) begin
      errors++; $display("FAIL basic_data: got %p, want 61 62 63 64", got_d);
    end
    checks++;
    if (got_l.size() != 4 || {got_l[0], got_l[1], got_l[2], got_l[3]} !== 4'b0001) begin
      errors++; $display("FAIL basic_last: got %p, want 0 0 0 1", got_l);
    end
    checks++;
    if (first_en != 1 || first_vld != 3) begin
      errors++; $display("FAIL basic_latency: first mem_r_en=%0d first m_valid=%0d, want 1 3", first_en, first_vld);
    end
    checks++;
    if (hs_cyc.size() != 4 || hs_cyc[0] != 3 || hs_cyc[3] != 6) begin
      errors++; $display("FAIL basic_consecutive: handshake cycles %p, want 3 4 5 6", hs_cyc);
    end
    checks++;
    if (done_cyc != 7 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL basic_done: done cycle=%0d busy=%b, want 7 0", done_cyc, busy_at_done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    run_xfer(8'h20, 9'd6, 1, -1, 80);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++) if (got_d[i] !== exp_byte(8'(8'h20 + i))) bad++;
    checks++;
    if (got_d.size() != 6 || bad != 0) begin
      errors++; $display("FAIL bp_data: got %p, want 20..25", got_d);
    end
    checks++;
    if (stall_bad != 0 || max_ahead > 2) begin
      errors++; $display("FAIL bp_stall: unstable stalls=%0d reads ahead=%0d, want 0 and <=2", stall_bad, max_ahead);
    end
    checks++;
    if (done_cyc < 0 || got_l.size() != 6 || got_l[5] !== 1'b1) begin
      errors++; $display("FAIL bp_done: done cycle=%0d, want done with m_last on byte 5", done_cyc);
    end
  endtask

  task automatic test_wrap();
    run_xfer(8'hFE, 9'd4, 0, -1, 30);
    checks++;
    if (addr_log.size() != 4 || addr_log[0] !== 8'hFE || addr_log[1] !== 8'hFF ||
        addr_log[2] !== 8'h00 || addr_log[3] !== 8'h01) begin
      errors++; $display("FAIL wrap_addr: got %p, want fe ff 00 01", addr_log);
    end
    checks++;
    if (got_d.size() != 4 || got_d[0] !== 8'hFE || got_d[1] !== 8'hFF || got_d[2] !== 8'h61 || got_d[3] !== 8'h62) begin
      errors++; $display("FAIL wrap_data: got %p, want fe ff 61 62", got_d);
    end
  endtask

  task automatic test_len_edges();
    int bad, lasts;
    run_xfer(8'h05, 9'd0, 0, -1, 10);
    checks++;
    if (done_cyc < 1 || done_cyc > 2 || n_iss != 0 || got_d.size() != 0) begin
      errors++; $display("FAIL len0: done cycle=%0d reads=%0d bytes=%0d, want done<=2 0 0", done_cyc, n_iss, got_d.size());
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL len0_pulse: done=%b, want 0", done);
    end
    run_xfer(8'h00, 9'd256, 0, -1, 300);
    bad = 0; lasts = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== exp_byte(8'(i))) bad++;
      if (got_l[i]) lasts++;
    end
    checks++;
    if (got_d.size() != 256 || bad != 0 || n_iss != 256) begin
      errors++; $display("FAIL len256_data: bytes=%0d bad=%0d reads=%0d, want 256 0 256", got_d.size(), bad, n_iss);
    end
    checks++;
    if (lasts != 1 || got_l.size() != 256 || got_l[255] !== 1'b1 || done_cyc < 0) begin
      errors++; $display("FAIL len256_last: m_last count=%0d done cycle=%0d, want 1 on final byte and done", lasts, done_cyc);
    end
  endtask

  task automatic test_stop();
    logic [7:0] seen[$];
    @(negedge clk); start = 1'b1; start_addr = 8'h40; length = 9'd8; m_ready = 1'b1;
    for (int i = 0; i < 20 && seen.size() < 2; i++) begin
      @(negedge clk); start = 1'b0;
      if (m_valid) seen.push_back(m_data);
    end
    @(negedge clk); m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seen.size() != 2 || seen[1] !== 8'h41 || m_valid !== 1'b1 || m_data !== 8'h42) begin
      errors++; $display("FAIL stop_setup: seen=%p m_valid=%b m_data=%h, want 40 41 then 42 held", seen, m_valid, m_data);
    end
    stop = 1'b1; #1;
    checks++;
    if (mem_r_en !== 1'b0) begin
      errors++; $display("FAIL stop_no_read: mem_r_en=%b, want 0", mem_r_en);
    end
    @(negedge clk); stop = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_flush: m_valid=%b done=%b busy=%b, want 0 1 0", m_valid, done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL stop_idle: done=%b m_valid=%b, want 0 0", done, m_valid);
    end
    run_xfer(8'h00, 9'd2, 0, 2, 20);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 8'h61 || got_d[1] !== 8'h62 || done_cyc < 0) begin
      errors++; $display("FAIL stop_next_xfer: got %p done cycle=%0d, want 61 62 and done", got_d, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); start = 1'b1; start_addr = 8'h00; length = 9'd8; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_active: busy=%b m_valid=%b, want 1 1", busy, m_valid);
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, m_valid, m_last, mem_r_en} !== 5'b0 || m_data !== 8'h00 || mem_r_addr !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b done=%b m_valid=%b m_last=%b mem_r_en=%b m_data=%h addr=%h, want all 0",
               busy, done, m_valid, m_last, mem_r_en, m_data, mem_r_addr);
    end
    rst_n = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    run_xfer(8'h00, 9'd2, 0, 2, 20);
    checks++;
    if (got_d.size() != 2 || got_d[0] !== 8'h61 || got_d[1] !== 8'h62) begin
      errors++; $display("FAIL rstmid_recover: got %p, want 61 62", got_d);
    end
  endtask

  task automatic test_loop();
    int bad;
    run_xfer(8'h10, 9'd3, 0, 9, 40);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== 8'(8'h10 + i % 3) || got_l[i] !== (i % 3 == 2)) bad++;
    checks++;
    if (got_d.size() != 9 || bad != 0) begin
      errors++; $display("FAIL loop_data: got %p last %p, want 10 11 12 repeated, last every 3rd", got_d, got_l);
    end
    checks++;
    if (hs_cyc.size() != 9 || hs_cyc[8] - hs_cyc[0] != 8) begin
      errors++; $display("FAIL loop_bubble: handshake cycles %p, want 9 consecutive", hs_cyc);
    end
    checks++;
    if (stop_cyc < 0 || done_cyc != stop_cyc + 1) begin
      errors++; $display("FAIL loop_done: stop cycle=%0d done cycle=%0d, want done right after stop", stop_cyc, done_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = exp_byte(8'(i));
    test_reset();
`ifdef BRAM_STREAM_READER_LOOP_EN
    test_loop();
    test_stop();
`else
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_edges();
    test_stop();
    test_reset_mid();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
